// File: rtl/tx_serial_pkg.sv
// Shared types and helpers for the tx_serial_fila UART transmitter.
// Holds the FSM state encoding and the baud divider calculation.
package tx_serial_pkg;

   typedef enum logic [2:0] {
      OCIOSO   = 3'd0,
      INICIO   = 3'd1,
      DADOS    = 3'd2,
      PARIDADE = 3'd3,
      PARADA   = 3'd4
   } estado_t;

   // Clocks per bit, rounded to the nearest integer.
   function automatic int calc_div(input longint clk_hz, input longint baud);
      return int'((clk_hz + baud / 2) / baud);
   endfunction

endpackage

// File: rtl/fila_tx.sv
// Synchronous FIFO (DATA_BITS x FIFO_DEPTH) feeding the UART shift register.
// Head word is presented combinationally on dout; a pop advances it.
module fila_tx #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        push,
   input  logic [DATA_BITS-1:0]        din,
   input  logic                        pop,
   output logic [DATA_BITS-1:0]        dout,
   output logic                        vazio,
   output logic                        cheio,
   output logic [$clog2(FIFO_DEPTH):0] count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] CHEIO_N = (AW + 1)'(FIFO_DEPTH);

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic                 push_ok;
   logic                 pop_ok;

   assign vazio   = (count == '0);
   assign cheio   = (count == CHEIO_N);
   assign push_ok = push && !cheio;
   assign pop_ok  = pop && !vazio;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally; count carries the extra bit to tell full from empty.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tx_serial_fila.sv
// UART transmitter with TX FIFO driving saida_serial (8N1 by default, LSB first).
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module tx_serial_fila
   import tx_serial_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] dados,
   input  logic                 escreve,
   output logic                 pronto,
   output logic                 saida_serial,
   output logic                 ocupado,
   output logic                 vazio,
   output logic                 db_overflow
);
   localparam int DIV = calc_div(longint'(CLK_HZ), longint'(BAUD));
   localparam int TW  = $clog2(DIV + 1);
   localparam logic [TW-1:0] DIV_M1 = TW'(DIV - 1);
   localparam logic [2:0] ULTIMO_BIT = 3'(DATA_BITS - 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] CHEIO_N = (AW + 1)'(FIFO_DEPTH);

   estado_t              estado;
   logic [TW-1:0]        tick;
   logic [2:0]           bit_cnt;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] fifo_dout;
   logic [AW:0]          fifo_count;
   logic                 cheio;
   logic                 fim_bit;
   logic                 pop;
   logic                 linha_prox;
`ifdef UART_TX_PARITY_EN
   logic                 paridade;
`endif

   fila_tx #(
      .DATA_BITS (DATA_BITS),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fila (
      .clock(clock),
      .reset(reset),
      .push (escreve),
      .din  (dados),
      .pop  (pop),
      .dout (fifo_dout),
      .vazio(vazio),
      .cheio(cheio),
      .count(fifo_count)
   );

   assign pronto  = (fifo_count != CHEIO_N);
   assign ocupado = (estado != OCIOSO);
   assign fim_bit = (tick == DIV_M1);
   // Pop when idle, or at the very end of a stop bit so frames run back-to-back.
   assign pop     = !vazio && ((estado == OCIOSO) || ((estado == PARADA) && fim_bit));

   always_comb begin
      linha_prox = 1'b1;
      case (estado)
         INICIO:   linha_prox = 1'b0;
         DADOS:    linha_prox = shift[0];
`ifdef UART_TX_PARITY_EN
         PARIDADE: linha_prox = paridade;
`endif
         default:  linha_prox = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado       <= OCIOSO;
         tick         <= '0;
         bit_cnt      <= '0;
         shift        <= '0;
         saida_serial <= 1'b1;
         db_overflow  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         paridade     <= 1'b0;
`endif
      end else begin
         saida_serial <= linha_prox;
         if (escreve && cheio) begin
            db_overflow <= 1'b1;
         end
         if (estado != OCIOSO) begin
            tick <= fim_bit ? '0 : tick + 1'b1;
         end
         if (pop) begin
            shift  <= fifo_dout;
            tick   <= '0;
            estado <= INICIO;
`ifdef UART_TX_PARITY_EN
            paridade <= ^fifo_dout;
`endif
         end else begin
            case (estado)
               OCIOSO: estado <= OCIOSO;
               INICIO: begin
                  if (fim_bit) begin
                     estado  <= DADOS;
                     bit_cnt <= '0;
                  end
               end
               DADOS: begin
                  if (fim_bit) begin
                     shift <= shift >> 1;
                     if (bit_cnt == ULTIMO_BIT) begin
`ifdef UART_TX_PARITY_EN
                        estado <= PARIDADE;
`else
                        estado <= PARADA;
`endif
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end
`ifdef UART_TX_PARITY_EN
               PARIDADE: begin
                  if (fim_bit) begin
                     estado <= PARADA;
                  end
               end
`endif
               PARADA: begin
                  if (fim_bit) begin
                     estado <= OCIOSO;
                  end
               end
               default: estado <= OCIOSO;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tx_serial_fila.sv
// Self-checking bench for tx_serial_fila: directed writes, a UART receiver monitor
// decodes the line and compares each frame against a queue of expected bytes.
module tb_tx_serial_fila;

   localparam int DIV = 434;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_CLKS = NBITS * DIV;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] dados = 8'h00;
   logic       escreve = 1'b0;
   logic       pronto;
   logic       saida_serial;
   logic       ocupado;
   logic       vazio;
   logic       db_overflow;

   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         frames_rx = 0;
   logic [7:0] exp_q[$];
   int         starts[$];
   logic       pars[$];

   tx_serial_fila dut (
      .clock       (clock),
      .reset       (reset),
      .dados       (dados),
      .escreve     (escreve),
      .pronto      (pronto),
      .saida_serial(saida_serial),
      .ocupado     (ocupado),
      .vazio       (vazio),
      .db_overflow (db_overflow)
   );

   always #10 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic apply_stimulus(input logic [7:0] b, input bit aceito);
      @(negedge clock);
      dados   = b;
      escreve = 1'b1;
      if (aceito) exp_q.push_back(b);
      @(posedge clock);
   endtask

   task automatic end_stimulus();
      @(negedge clock);
      escreve = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!(vazio && !ocupado && exp_q.size() == 0) && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (n >= budget) check_output("drain_timeout", 32'd1, 32'd0);
      repeat (20) @(negedge clock);
   endtask

   task automatic rx_wait(input int n, output bit aborted);
      aborted = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         if (!reset) begin
            aborted = 1'b1;
            return;
         end
      end
   endtask

   // Receiver monitor: samples each bit at its middle, drops frames cut by reset.
   initial begin : monitor
      logic       prev;
      logic [7:0] b;
      logic       par;
      logic [7:0] e;
      bit         ab;
      int         st;
      prev = 1'b1;
      par  = 1'b0;
      forever begin
         @(negedge clock);
         if (reset && prev && !saida_serial) begin
            st = cyc;
            b  = 8'h00;
            rx_wait(DIV / 2, ab);
            if (!ab) check_output("start_bit", {31'd0, saida_serial}, 32'd0);
            for (int k = 0; k < 8; k++) begin
               if (!ab) rx_wait(DIV, ab);
               if (!ab) b[k] = saida_serial;
            end
`ifdef UART_TX_PARITY_EN
            if (!ab) rx_wait(DIV, ab);
            if (!ab) par = saida_serial;
`endif
            if (!ab) rx_wait(DIV, ab);
            if (!ab) begin
               check_output("stop_bit", {31'd0, saida_serial}, 32'd1);
               frames_rx++;
               starts.push_back(st);
               pars.push_back(par);
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("[TB] FAIL unexpected_frame: got %0h expected none", b);
               end else begin
                  e = exp_q.pop_front();
                  check_output("frame_data", {24'd0, b}, {24'd0, e});
`ifdef UART_TX_PARITY_EN
                  check_output("parity_bit", {31'd0, par}, {31'd0, ^e});
`endif
               end
            end
            prev = saida_serial;
         end else begin
            prev = saida_serial;
         end
      end
   end

   initial begin : watchdog
      repeat (200_000) @(posedge clock);
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int bad;
      int f0;

      // Test 1: reset values, then a long idle stretch
      repeat (5) @(posedge clock);
      @(negedge clock);
      check_output("rst_line",     {31'd0, saida_serial}, 32'd1);
      check_output("rst_ocupado",  {31'd0, ocupado},      32'd0);
      check_output("rst_vazio",    {31'd0, vazio},        32'd1);
      check_output("rst_pronto",   {31'd0, pronto},       32'd1);
      check_output("rst_overflow", {31'd0, db_overflow},  32'd0);
      reset = 1'b1;
      bad = 0;
      repeat (10_000) begin
         @(negedge clock);
         if (saida_serial !== 1'b1 || vazio !== 1'b1 || pronto !== 1'b1 || ocupado !== 1'b0) bad++;
      end
      check_output("idle_hold", bad, 32'd0);

      // Test 2: single 0x55, start bit two clocks after the write edge
      apply_stimulus(8'h55, 1'b1);
      end_stimulus();
      check_output("t2_line_e1",    {31'd0, saida_serial}, 32'd1);
      check_output("t2_vazio_e1",   {31'd0, vazio},        32'd0);
      @(negedge clock);
      check_output("t2_line_e2",    {31'd0, saida_serial}, 32'd1);
      check_output("t2_ocupado_e2", {31'd0, ocupado},      32'd1);
      @(negedge clock);
      check_output("t2_start_e3",   {31'd0, saida_serial}, 32'd0);
      repeat (FRAME_CLKS - 2) @(negedge clock);
      check_output("t2_ocupado_last", {31'd0, ocupado}, 32'd1);
      @(negedge clock);
      check_output("t2_ocupado_fall", {31'd0, ocupado}, 32'd0);
      wait_idle(FRAME_CLKS + 2000);

      // Test 3: three consecutive writes go out back-to-back in order
      starts.delete();
      apply_stimulus(8'h41, 1'b1);
      apply_stimulus(8'h42, 1'b1);
      apply_stimulus(8'h43, 1'b1);
      end_stimulus();
      repeat (1000) @(negedge clock);
      check_output("t3_vazio_f1", {31'd0, vazio}, 32'd0);
      repeat (2 * FRAME_CLKS - 800) @(negedge clock);
      check_output("t3_vazio_f3",   {31'd0, vazio},   32'd1);
      check_output("t3_ocupado_f3", {31'd0, ocupado}, 32'd1);
      wait_idle(FRAME_CLKS + 2000);
      check_output("t3_frames", starts.size(), 32'd3);
      if (starts.size() == 3) begin
         check_output("t3_gap12", starts[1] - starts[0], FRAME_CLKS);
         check_output("t3_gap23", starts[2] - starts[1], FRAME_CLKS);
      end

      // Test 4: ten writes into an idle transmitter, the tenth overflows
      f0 = frames_rx;
      for (int i = 0; i < 9; i++) apply_stimulus(8'(i), 1'b1);
      @(negedge clock);
      check_output("t4_pronto_full", {31'd0, pronto},      32'd0);
      check_output("t4_ovf_before",  {31'd0, db_overflow}, 32'd0);
      dados   = 8'h09;
      escreve = 1'b1;
      @(posedge clock);
      end_stimulus();
      check_output("t4_overflow", {31'd0, db_overflow}, 32'd1);
      wait_idle(9 * FRAME_CLKS + 2000);
      check_output("t4_frames",     frames_rx - f0, 32'd9);
      check_output("t4_ovf_sticky", {31'd0, db_overflow}, 32'd1);

      // Test 5: reset pulled mid-frame, nothing left over afterwards
      apply_stimulus(8'h00, 1'b1);
      end_stimulus();
      repeat (3 * DIV) @(negedge clock);
      reset = 1'b0;
      #1;
      check_output("t5_line",     {31'd0, saida_serial}, 32'd1);
      check_output("t5_vazio",    {31'd0, vazio},        32'd1);
      check_output("t5_ocupado",  {31'd0, ocupado},      32'd0);
      check_output("t5_overflow", {31'd0, db_overflow},  32'd0);
      exp_q.delete();
      repeat (3) @(negedge clock);
      f0 = frames_rx;
      reset = 1'b1;
      repeat (6000) @(negedge clock);
      check_output("t5_no_frame", frames_rx - f0, 32'd0);
      check_output("t5_idle_line", {31'd0, saida_serial}, 32'd1);

`ifdef UART_TX_PARITY_EN
      // Test 6: parity of 0x07 is 1, of 0x03 is 0; frames are 11 bits
      starts.delete();
      pars.delete();
      apply_stimulus(8'h07, 1'b1);
      apply_stimulus(8'h03, 1'b1);
      end_stimulus();
      wait_idle(2 * FRAME_CLKS + 2000);
      check_output("t6_frames", starts.size(), 32'd2);
      if (starts.size() == 2) begin
         check_output("t6_gap",  starts[1] - starts[0], 32'(11 * DIV));
         check_output("t6_par07", {31'd0, pars[0]}, 32'd1);
         check_output("t6_par03", {31'd0, pars[1]}, 32'd0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
